// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 GPR file of the five-stage MIPS core.
// Selects and commits the W-stage result, serves two bypassed D-stage reads, and counts retired instructions.
module wb_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_W,
    input  logic [31:0] data_dm_W,
    input  logic [31:0] data_alu_W,
    input  logic [1:0]  alu_w,
    input  logic [4:0]  writereg_W,
    input  logic [31:0] pcout_W,
    input  logic [31:0] hilo_W,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    output logic [31:0] rd1_D,
    output logic [31:0] rd2_D,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [31:0] retired
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MFLO    = 6'h12;

    logic [5:0]      op;
    logic [5:0]      funct;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_data;
    logic            is_load;
    logic            is_link;
    logic            is_hilo;
    logic [XLEN-1:0] gpr [NREGS];
    logic [XLEN-1:0] retired_q;

    assign op    = instr_W[31:26];
    assign funct = instr_W[5:0];

    // Little-endian lane extraction and extension for loads
    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = alu_w[1] ? data_dm_W[31:16] : data_dm_W[15:0];
        load_data = data_dm_W;
        is_load   = 1'b0;
        case (alu_w)
            2'd0:    byte_sel = data_dm_W[7:0];
            2'd1:    byte_sel = data_dm_W[15:8];
            2'd2:    byte_sel = data_dm_W[23:16];
            default: byte_sel = data_dm_W[31:24];
        endcase
        case (op)
            OP_LB:  begin is_load = 1'b1; load_data = {{24{byte_sel[7]}}, byte_sel}; end
            OP_LBU: begin is_load = 1'b1; load_data = {24'h0, byte_sel}; end
            OP_LH:  begin is_load = 1'b1; load_data = {{16{half_sel[15]}}, half_sel}; end
            OP_LHU: begin is_load = 1'b1; load_data = {16'h0, half_sel}; end
            OP_LW:  begin is_load = 1'b1; load_data = data_dm_W; end
            default: ;
        endcase
    end

    assign is_link = (op == OP_JAL) || (op == OP_SPECIAL && funct == FN_JALR);
    assign is_hilo = (op == OP_SPECIAL) && (funct == FN_MFHI || funct == FN_MFLO);

    // Write-back source: load > link > HI/LO > ALU
    always_comb begin
        wb_data = data_alu_W;
        if (is_load)
            wb_data = load_data;
        else if (is_link)
            wb_data = pcout_W + XLEN'(8);
        else if (is_hilo)
            wb_data = hilo_W;
    end

    assign wb_we   = (writereg_W != 5'd0);
    assign wb_addr = writereg_W;
    assign retired = retired_q;

    // Register 0 is forced to read zero; otherwise W-stage bypass beats the array
    always_comb begin
        rd1_D = gpr[rs_D];
        if (rs_D == 5'd0)
            rd1_D = '0;
        else if (wb_we && rs_D == writereg_W)
            rd1_D = wb_data;

        rd2_D = gpr[rt_D];
        if (rt_D == 5'd0)
            rd2_D = '0;
        else if (wb_we && rt_D == writereg_W)
            rd2_D = wb_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++)
                gpr[i] <= '0;
        end else if (wb_we) begin
            gpr[writereg_W] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            retired_q <= '0;
        else if (instr_W != '0)
            retired_q <= retired_q + XLEN'(1);
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed W-stage vectors queue expected values, a monitor compares them.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] instr_W, data_dm_W, data_alu_W, pcout_W, hilo_W;
    logic [1:0]  alu_w;
    logic [4:0]  writereg_W, rs_D, rt_D;
    logic [31:0] rd1_D, rd2_D, wb_data, retired;
    logic        wb_we;
    logic [4:0]  wb_addr;

    wb_regfile dut (
        .clk(clk), .reset(reset), .instr_W(instr_W), .data_dm_W(data_dm_W),
        .data_alu_W(data_alu_W), .alu_w(alu_w), .writereg_W(writereg_W),
        .pcout_W(pcout_W), .hilo_W(hilo_W), .rs_D(rs_D), .rt_D(rt_D),
        .rd1_D(rd1_D), .rd2_D(rd2_D), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .retired(retired)
    );

    localparam logic [31:0] I_ADDU = 32'h0000_0021;
    localparam logic [31:0] I_JAL  = 32'h0C00_0000;
    localparam logic [31:0] I_JALR = 32'h0000_0009;
    localparam logic [31:0] I_MFHI = 32'h0000_0010;
    localparam logic [31:0] I_MFLO = 32'h0000_0012;

    typedef enum int {S_RD1, S_RD2, S_DATA, S_WE, S_ADDR, S_RET} sel_e;
    typedef struct {
        sel_e        sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    event chk_ev;
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic expect_val(input sel_e s, input logic [31:0] v, input string name);
        exp_t e;
        e.sel = s; e.exp = v; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic sample();
        -> chk_ev;
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] dm, input logic [31:0] alu,
                         input logic [1:0] aw, input logic [4:0] wreg,
                         input logic [31:0] pc, input logic [31:0] hilo);
        instr_W = instr; data_dm_W = dm; data_alu_W = alu; alu_w = aw;
        writereg_W = wreg; pcout_W = pc; hilo_W = hilo;
    endtask

    // Monitor: on each sample point, pop every queued expectation and compare against the DUT
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(chk_ev);
            while (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                case (e.sel)
                    S_RD1:   act = rd1_D;
                    S_RD2:   act = rd2_D;
                    S_DATA:  act = wb_data;
                    S_WE:    act = 32'(wb_we);
                    S_ADDR:  act = 32'(wb_addr);
                    default: act = retired;
                endcase
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        logic [31:0] ld_instr [7];
        logic [1:0]  ld_aw    [7];
        logic [31:0] ld_exp   [7];
        logic        pat      [8];

        ld_instr = '{32'h8000_0000, 32'h9000_0000, 32'h8400_0000, 32'h9400_0000,
                     32'h8C00_0000, 32'h8000_0000, 32'h8400_0000};
        ld_aw    = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd3};
        ld_exp   = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                     32'h80FF_7F01, 32'h0000_007F, 32'hFFFF_80FF};
        pat      = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        reset = 1'b1;
        rs_D = 5'd0; rt_D = 5'd0;
        drive(32'h0, 32'h0, 32'h0, 2'd0, 5'd0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);

        // Reset state
        rs_D = 5'd5;
        expect_val(S_RET, 32'h0, "reset_retired");
        expect_val(S_RD1, 32'h0, "reset_rd1");
        expect_val(S_WE,  32'h0, "reset_we");
        sample();
        reset = 1'b0;

        // Write GPR5, then reset mid-cycle
        @(negedge clk);
        drive(I_ADDU, 32'h0, 32'h0000_1234, 2'd0, 5'd5, 32'h0, 32'h0);
        expect_val(S_WE,   32'h1,         "alu_we");
        expect_val(S_ADDR, 32'h5,         "alu_addr");
        expect_val(S_DATA, 32'h0000_1234, "alu_data");
        expect_val(S_RD1,  32'h0000_1234, "alu_bypass_rd1");
        sample();
        @(negedge clk);
        drive(32'h0, 32'h0, 32'h0, 2'd0, 5'd0, 32'h0, 32'h0);
        expect_val(S_RD1, 32'h0000_1234, "gpr5_written");
        expect_val(S_RET, 32'h1,         "retired_one");
        sample();
        reset = 1'b1;
        #1;
        expect_val(S_RD1, 32'h0, "midreset_rd1");
        expect_val(S_RET, 32'h0, "midreset_retired");
        sample();
        reset = 1'b0;

        // Dual-port bypass, then array read after commit
        @(negedge clk);
        drive(I_ADDU, 32'h0, 32'hCAFE_BABE, 2'd0, 5'd9, 32'h0, 32'h0);
        rs_D = 5'd9; rt_D = 5'd9;
        expect_val(S_RD1, 32'hCAFE_BABE, "bypass_rd1");
        expect_val(S_RD2, 32'hCAFE_BABE, "bypass_rd2");
        sample();
        rt_D = 5'd5;
        expect_val(S_RD2, 32'h0, "rd2_cleared_gpr5");
        sample();
        @(negedge clk);
        drive(32'h0, 32'h0, 32'h0, 2'd0, 5'd0, 32'h0, 32'h0);
        rt_D = 5'd9;
        expect_val(S_RD1, 32'hCAFE_BABE, "array_rd1");
        expect_val(S_RD2, 32'hCAFE_BABE, "array_rd2");
        expect_val(S_RET, 32'h1,         "retired_after_bypass");
        sample();

        // Load extraction
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(ld_instr[i], 32'h80FF_7F01, 32'h1111_1111, ld_aw[i], 5'd10, 32'h0, 32'h0);
            expect_val(S_DATA, ld_exp[i], $sformatf("load_%0d", i));
            sample();
        end

        // Link and HI/LO sources
        @(negedge clk);
        drive(I_JAL, 32'h0, 32'h0000_DEAD, 2'd0, 5'd31, 32'h0000_3010, 32'h0);
        expect_val(S_DATA, 32'h0000_3018, "jal_data");
        sample();
        @(negedge clk);
        drive(I_MFHI, 32'h0, 32'h0000_DEAD, 2'd0, 5'd4, 32'h0, 32'h55AA_55AA);
        expect_val(S_DATA, 32'h55AA_55AA, "mfhi_data");
        sample();
        @(negedge clk);
        drive(I_MFLO, 32'h0, 32'h0000_DEAD, 2'd0, 5'd6, 32'h0, 32'h1234_5678);
        expect_val(S_DATA, 32'h1234_5678, "mflo_data");
        sample();
        @(negedge clk);
        drive(I_JALR, 32'h0, 32'h0000_DEAD, 2'd0, 5'd2, 32'hFFFF_FFFC, 32'h0);
        expect_val(S_DATA, 32'h0000_0004, "jalr_wrap");
        sample();
        @(negedge clk);
        drive(32'h0, 32'h0, 32'h0, 2'd0, 5'd0, 32'h0, 32'h0);
        rs_D = 5'd31; rt_D = 5'd4;
        expect_val(S_RD1, 32'h0000_3018, "gpr31_link");
        expect_val(S_RD2, 32'h55AA_55AA, "gpr4_hi");
        sample();
        rs_D = 5'd6; rt_D = 5'd2;
        expect_val(S_RD1, 32'h1234_5678, "gpr6_lo");
        expect_val(S_RD2, 32'h0000_0004, "gpr2_jalr");
        expect_val(S_RET, 32'd12,        "retired_twelve");
        sample();

        // $zero protection
        @(negedge clk);
        drive(I_ADDU, 32'h0, 32'hFFFF_FFFF, 2'd0, 5'd0, 32'h0, 32'h0);
        rs_D = 5'd0; rt_D = 5'd0;
        expect_val(S_WE,   32'h0,         "zero_we");
        expect_val(S_ADDR, 32'h0,         "zero_addr");
        expect_val(S_DATA, 32'hFFFF_FFFF, "zero_data");
        expect_val(S_RD1,  32'h0,         "zero_rd1");
        expect_val(S_RD2,  32'h0,         "zero_rd2");
        sample();

        // Retired counter with bubbles, then wrap
        @(negedge clk);
        drive(32'h0, 32'h0, 32'h0, 2'd0, 5'd0, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            instr_W = pat[i] ? I_ADDU : 32'h0;
        end
        @(negedge clk);
        instr_W = 32'h0;
        expect_val(S_RET, 32'd5, "retired_five");
        sample();
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        expect_val(S_RET, 32'hFFFF_FFFF, "retired_preset");
        sample();
        instr_W = I_ADDU;
        @(negedge clk);
        instr_W = 32'h0;
        expect_val(S_RET, 32'h0, "retired_wrap");
        sample();

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and general-purpose register file of the five-stage MIPS core. It consumes the fields latched by the M→W pipeline register, extracts and extends load data, selects the write-back value, and commits it to the 32×32 GPR array. It also serves the two combinational D-stage read ports with internal W→D bypass and keeps a retired-instruction counter for the grading trace.

## Interface
- No parameters. Widths are fixed at a 32-bit datapath and 32 registers.
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high. Clears every register.
- instr_W  input  32  instruction in W stage; 32'h0 is a bubble or nop.
- data_dm_W  input  32  raw aligned word read from data memory.
- data_alu_W  input  32  ALU result.
- alu_w  input  2  low two bits of the effective address, used as the byte offset.
- writereg_W  input  5  destination register; 0 means no write.
- pcout_W  input  32  PC of the W-stage instruction.
- hilo_W  input  32  HI or LO value already selected in M.
- rs_D  input  5  read address, port 1.
- rt_D  input  5  read address, port 2.
- rd1_D  output  32  read data, port 1, with bypass.
- rd2_D  output  32  read data, port 2, with bypass.
- wb_we  output  1  write-back commit this cycle.
- wb_addr  output  5  equals writereg_W.
- wb_data  output  32  selected write-back value.
- retired  output  32  count of non-bubble instructions that have left W.

## Operation
- Decode `instr_W`:
  - op = [31:26]
  - funct = [5:0]
- Write-back source priority:
  1. Load (op 0x23 lw, 0x20 lb, 0x24 lbu, 0x21 lh, 0x25 lhu) → extracted memory data.
  2. jal (op 0x03), or jalr (op 0, funct 0x09) → pcout_W + 8. The 32-bit add wraps.
  3. mfhi or mflo (op 0, funct 0x10 / 0x12) → hilo_W.
  4. Otherwise → data_alu_W.
- Load extraction, little-endian lanes:
  - byte lane k = data_dm_W[8k+7:8k], with k = alu_w.
  - halfword = data_dm_W[31:16] if alu_w[1], else [15:0]. alu_w[0] is ignored.
  - lb and lh sign-extend; lbu and lhu zero-extend; lw passes the word through.
- wb_we = (writereg_W != 0). Write enable is derived only from writereg_W; the pipeline zeroes writereg_W for non-writing instructions.
- GPR[0] reads as 0 at all times and is never written.
- Read port n returns:
  - 0 if its address is 0;
  - else wb_data if wb_we and the address equals writereg_W (bypass);
  - else GPR[address].
- retired increments by 1 on each clock edge where instr_W != 0. It wraps from 2^32−1 to 0.

## Timing
- Reset asserted, asynchronously: all GPR[1..31] = 0 and retired = 0 immediately, without waiting for a clock edge. The combinational outputs then follow their inputs: rd1_D/rd2_D return 0 for any non-bypassed address, and wb_data, wb_we and wb_addr track the W-stage inputs.
- Reset deasserted: normal operation starts at the next rising edge. A write pending at that edge commits.
- Write latency: the array updates at the rising edge that ends the W cycle.
- Same-cycle visibility: the bypass makes the value visible on rd1_D/rd2_D during that W cycle, with zero-cycle read-after-write.
- Reads are purely combinational from rs_D/rt_D, the array, and the W inputs. No read latency.
- Both ports may bypass at once, with the same or different addresses.
- A read of register 0 while writereg_W = 0 returns 0.
- retired and wb_* are visible the cycle the instruction is in W. retired reflects the count through the previous edge.

## Test plan
- Reset mid-run:
  - Stimulus: write GPR[5] = 0x1234, then pulse reset between clock edges.
  - Required: rd1_D(rs_D=5) = 0 and retired = 0 before the next edge.
- Bypass:
  - Stimulus: writereg_W = 9, ALU instr, data_alu_W = 0xCAFEBABE, rs_D = rt_D = 9 in the same cycle.
  - Required: both ports return 0xCAFEBABE. After the edge, with writereg_W = 0, they still return it.
- Load extension:
  - Stimulus: data_dm_W = 0x80FF7F01.
  - Required:
    - lb with alu_w = 3 → 0xFFFFFF80
    - lbu with alu_w = 3 → 0x00000080
    - lh with alu_w = 2 → 0xFFFF80FF
    - lhu with alu_w = 0 → 0x00007F01
    - lw → 0x80FF7F01
- Link and HI/LO:
  - Stimulus: jal with pcout_W = 0x00003010, writereg_W = 31; then mfhi with hilo_W = 0x55AA55AA, writereg_W = 4.
  - Required: GPR[31] = 0x00003018 and GPR[4] = 0x55AA55AA.
- $zero protection:
  - Stimulus: ALU instr with writereg_W = 0, data_alu_W = 0xFFFFFFFF.
  - Required: wb_we = 0 and rd1_D(rs_D=0) = 0.
- Counter:
  - Stimulus: 5 non-zero instructions interleaved with 3 bubbles (instr_W = 0).
  - Required: retired = 5.
  - Then force the counter to 0xFFFFFFFF by sequence or backdoor, retire one more instruction, and require retired = 0.
